// File: rtl/item_entry_pkg.sv
// Shared types and constants for the keypad item-code entry front-end.
package item_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_HOLD    = 2'd3
  } entry_state_t;

  localparam int unsigned ITEM_IDX_W             = 5;
  localparam int unsigned TMO_CNT_W              = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 5;
  localparam int unsigned DEFAULT_MAX_ITEM       = 19;
  localparam int unsigned TENS_DIGIT_MIN         = 0;
  localparam int unsigned TENS_DIGIT_MAX         = 1;
  localparam int unsigned UNITS_DIGIT_MAX        = 9;

  // tens is 0 or 1, units 0..9, so the 5-bit result never exceeds 19
  function automatic logic [ITEM_IDX_W-1:0] item_index(input logic       tens,
                                                       input logic [3:0] units);
    logic [ITEM_IDX_W-1:0] base;
    base = tens ? ITEM_IDX_W'(10) : '0;
    return base + {1'b0, units};
  endfunction

endpackage

// File: rtl/item_code_entry_if.sv
// Keypad/selection bundle between the card/keypad side and the vending controller.
interface item_code_entry_if
  import item_entry_pkg::*;
#(
  parameter int unsigned CODE_W = 4
);

  logic                  CARD_IN;
  logic                  KEY_PRESS;
  logic [CODE_W-1:0]     ITEM_CODE;
  logic                  ACCEPT;
  logic                  SEL_VALID;
  logic [ITEM_IDX_W-1:0] SEL_ITEM;
  logic                  INVALID_SEL;
  logic                  TIMEOUT;
  logic                  BUSY;

  modport master (
    output CARD_IN, KEY_PRESS, ITEM_CODE, ACCEPT,
    input  SEL_VALID, SEL_ITEM, INVALID_SEL, TIMEOUT, BUSY
  );

  modport slave (
    input  CARD_IN, KEY_PRESS, ITEM_CODE, ACCEPT,
    output SEL_VALID, SEL_ITEM, INVALID_SEL, TIMEOUT, BUSY
  );

endinterface

// File: rtl/key_edge_detect.sv
// Rising-edge detector on a level that is already synchronous to clk.
module key_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  // armed_q withholds the first post-reset sample, so a level held high
  // through reset is not mistaken for a fresh rising edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/item_code_entry.sv
// Two-digit item-code entry with per-digit timeout and valid/accept hand-off.
module item_code_entry
  import item_entry_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned MAX_ITEM       = DEFAULT_MAX_ITEM,
  parameter int unsigned CODE_W         = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  item_code_entry_if.slave  bus
);

  entry_state_t          state_q;
  logic [TMO_CNT_W-1:0]  tmo_q;
  logic                  tens_q;
  logic                  sel_valid_q;
  logic [ITEM_IDX_W-1:0] sel_item_q;
  logic                  invalid_q;
  logic                  timeout_q;
  logic                  busy_q;

  logic                  key_rise;
  logic                  card_rise;
  logic [CODE_W-1:0]     digit;
  logic                  digit_is_tens0;
  logic                  digit_is_tens1;
  logic                  digit_is_units;
  logic [ITEM_IDX_W-1:0] item_sum;
  logic                  item_legal;
  logic                  tmo_expire;

  key_edge_detect u_key_edge (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .level_i (bus.KEY_PRESS),
    .rise_o  (key_rise)
  );

  key_edge_detect u_card_edge (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .level_i (bus.CARD_IN),
    .rise_o  (card_rise)
  );

  assign digit          = bus.ITEM_CODE;
  assign digit_is_tens0 = (digit == CODE_W'(TENS_DIGIT_MIN));
  assign digit_is_tens1 = (digit == CODE_W'(TENS_DIGIT_MAX));
  assign digit_is_units = (digit <= CODE_W'(UNITS_DIGIT_MAX));
  assign item_sum       = item_index(tens_q, digit[3:0]);
  assign item_legal     = digit_is_units && (item_sum <= ITEM_IDX_W'(MAX_ITEM));
  assign tmo_expire     = (tmo_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      tens_q      <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_item_q  <= '0;
      invalid_q   <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      invalid_q <= 1'b0;
      timeout_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (card_rise) begin
            state_q <= ST_WAIT_D1;
            tmo_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_WAIT_D1: begin
          if (!bus.CARD_IN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (key_rise) begin
            if (digit_is_tens0 || digit_is_tens1) begin
              tens_q  <= digit_is_tens1;
              state_q <= ST_WAIT_D2;
              tmo_q   <= '0;
            end else begin
              invalid_q <= 1'b1;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end
          end else if (tmo_expire) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        ST_WAIT_D2: begin
          if (!bus.CARD_IN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (key_rise) begin
            if (item_legal) begin
              sel_item_q  <= item_sum;
              sel_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end else begin
              invalid_q <= 1'b1;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end
          end else if (tmo_expire) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        ST_HOLD: begin
          if (!bus.CARD_IN || bus.ACCEPT) begin
            sel_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          sel_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SEL_VALID   = sel_valid_q;
  assign bus.SEL_ITEM    = sel_item_q;
  assign bus.INVALID_SEL = invalid_q;
  assign bus.TIMEOUT     = timeout_q;
  assign bus.BUSY        = busy_q;

endmodule

// File: tb/tb_item_code_entry.sv
// Scoreboard bench for item_code_entry: stimulus queues expected events, a monitor checks them.
module tb_item_code_entry;

  localparam int EV_NONE  = 0;
  localparam int EV_VALID = 1;
  localparam int EV_DROP  = 2;
  localparam int EV_INV   = 3;
  localparam int EV_TO    = 4;

  typedef struct {
    int kind;
    int item;
    int edge_n;
  } ev_t;

  logic CLK;
  logic RESET_N;
  int   cyc;
  int   tests;
  int   fails;
  logic prev_valid;
  ev_t  sb[$];

  item_code_entry_if #(.CODE_W(4)) bus ();

  item_code_entry #(
    .TIMEOUT_CYCLES (5),
    .MAX_ITEM       (19),
    .CODE_W         (4)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic string kname(input int k);
    case (k)
      EV_VALID: return "SEL_VALID_rise";
      EV_DROP:  return "SEL_VALID_fall";
      EV_INV:   return "INVALID_SEL";
      EV_TO:    return "TIMEOUT";
      default:  return "none";
    endcase
  endfunction

  task automatic sb_check(input int kind, input int item);
    ev_t x;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got %s item=%0d at edge %0d, required none",
               kname(kind), item, cyc);
    end else begin
      x = sb.pop_front();
      if (x.kind != kind || x.item != item || x.edge_n != cyc) begin
        fails++;
        $display("FAIL event_%s: got %s item=%0d edge=%0d, required %s item=%0d edge=%0d",
                 kname(x.kind), kname(kind), item, cyc, kname(x.kind), x.item, x.edge_n);
      end
    end
  endtask

  initial prev_valid = 1'b0;
  always @(negedge CLK) begin
    if (bus.SEL_VALID && !prev_valid) sb_check(EV_VALID, int'(bus.SEL_ITEM));
    if (!bus.SEL_VALID && prev_valid) sb_check(EV_DROP, 0);
    if (bus.INVALID_SEL)              sb_check(EV_INV, 0);
    if (bus.TIMEOUT)                  sb_check(EV_TO, 0);
    prev_valid = bus.SEL_VALID;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int item, input int edge_n);
    ev_t x;
    x.kind   = kind;
    x.item   = item;
    x.edge_n = edge_n;
    sb.push_back(x);
  endtask

  // returns just after a falling edge; e is the rising edge that samples what is driven next
  task automatic at_neg(output int e);
    @(negedge CLK);
    #1;
    e = cyc + 1;
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) at_neg(e);
  endtask

  // key held for two cycles, then released; kind/item describe the expected DUT reaction
  task automatic key_in(input logic [3:0] code, input int kind, input int item, output int k);
    int e;
    at_neg(e);
    bus.KEY_PRESS = 1'b1;
    bus.ITEM_CODE = code;
    k = e;
    if (kind != EV_NONE) expect_ev(kind, item, e);
    at_neg(e);
    at_neg(e);
    bus.KEY_PRESS = 1'b0;
  endtask

  function automatic int outs_word();
    return int'({bus.SEL_VALID, bus.SEL_ITEM, bus.INVALID_SEL, bus.TIMEOUT, bus.BUSY});
  endfunction

  initial begin
    int e, e0, k;
    tests = 0;
    fails = 0;
    bus.CARD_IN   = 1'b0;
    bus.KEY_PRESS = 1'b0;
    bus.ITEM_CODE = '0;
    bus.ACCEPT    = 1'b0;
    RESET_N       = 1'b0;
    #3;
    chk("reset_outputs", outs_word(), 0);
    idle(2);
    RESET_N = 1'b1;
    idle(2);

    // keys 1,4 -> 14, ACCEPT low three cycles then high
    at_neg(e); bus.CARD_IN = 1'b1;
    key_in(4'd1, EV_NONE, 0, k);
    key_in(4'd4, EV_VALID, 14, k);
    at_neg(e);
    at_neg(e);
    chk("hold_valid", int'(bus.SEL_VALID), 1);
    chk("hold_item_14", int'(bus.SEL_ITEM), 14);
    chk("hold_busy", int'(bus.BUSY), 1);
    bus.ACCEPT = 1'b1;
    expect_ev(EV_DROP, 0, e);
    at_neg(e);
    bus.ACCEPT = 1'b0;
    chk("busy_after_accept", int'(bus.BUSY), 0);
    bus.CARD_IN = 1'b0;
    idle(2);

    // illegal first digit
    at_neg(e); bus.CARD_IN = 1'b1;
    key_in(4'd2, EV_INV, 0, k);
    chk("busy_after_bad_tens", int'(bus.BUSY), 0);
    chk("valid_after_bad_tens", int'(bus.SEL_VALID), 0);
    at_neg(e); bus.CARD_IN = 1'b0;
    idle(2);

    // 1,9 -> 19 is the highest legal index
    at_neg(e); bus.CARD_IN = 1'b1;
    key_in(4'd1, EV_NONE, 0, k);
    key_in(4'd9, EV_VALID, 19, k);
    at_neg(e); bus.ACCEPT = 1'b1;
    expect_ev(EV_DROP, 0, e);
    at_neg(e); bus.ACCEPT = 1'b0; bus.CARD_IN = 1'b0;
    idle(2);

    // 1,0xA -> illegal units digit
    at_neg(e); bus.CARD_IN = 1'b1;
    key_in(4'd1, EV_NONE, 0, k);
    key_in(4'hA, EV_INV, 0, k);
    at_neg(e); bus.CARD_IN = 1'b0;
    idle(2);

    // no keys: timeout on the fifth idle edge after the card edge
    at_neg(e0); bus.CARD_IN = 1'b1;
    expect_ev(EV_TO, 0, e0 + 5);
    idle(7);
    chk("busy_after_timeout", int'(bus.BUSY), 0);
    at_neg(e); bus.CARD_IN = 1'b0;
    idle(2);

    // key on the expiry edge wins; WAIT_D2 counter restarts from that key
    at_neg(e0); bus.CARD_IN = 1'b1;
    idle(4);
    key_in(4'd0, EV_NONE, 0, k);
    chk("busy_key_on_expiry", int'(bus.BUSY), 1);
    expect_ev(EV_TO, 0, k + 5);
    idle(5);
    chk("busy_after_d2_timeout", int'(bus.BUSY), 0);
    at_neg(e); bus.CARD_IN = 1'b0;
    idle(2);

    // card removal in HOLD, then a fresh insertion
    at_neg(e); bus.CARD_IN = 1'b1;
    key_in(4'd0, EV_NONE, 0, k);
    key_in(4'd7, EV_VALID, 7, k);
    at_neg(e);
    at_neg(e); bus.CARD_IN = 1'b0;
    expect_ev(EV_DROP, 0, e);
    at_neg(e);
    chk("busy_after_card_pull", int'(bus.BUSY), 0);
    at_neg(e); bus.CARD_IN = 1'b1;
    key_in(4'd0, EV_NONE, 0, k);
    key_in(4'd5, EV_VALID, 5, k);
    at_neg(e); bus.ACCEPT = 1'b1;
    expect_ev(EV_DROP, 0, e);
    at_neg(e); bus.ACCEPT = 1'b0; bus.CARD_IN = 1'b0;
    idle(2);

    // asynchronous reset mid-WAIT_D2 with the card left in
    at_neg(e); bus.CARD_IN = 1'b1;
    key_in(4'd1, EV_NONE, 0, k);
    chk("busy_in_wait_d2", int'(bus.BUSY), 1);
    #2 RESET_N = 1'b0;
    #1 chk("async_reset_outputs", outs_word(), 0);
    idle(2);
    RESET_N = 1'b1;
    idle(8);
    chk("held_card_no_rearm", int'(bus.BUSY), 0);
    at_neg(e); bus.CARD_IN = 1'b0;
    at_neg(e); bus.CARD_IN = 1'b1;
    key_in(4'd0, EV_NONE, 0, k);
    key_in(4'd3, EV_VALID, 3, k);
    at_neg(e); bus.ACCEPT = 1'b1;
    expect_ev(EV_DROP, 0, e);
    at_neg(e); bus.ACCEPT = 1'b0; bus.CARD_IN = 1'b0;
    idle(3);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/item_code_entry.md
Name: item_code_entry

Overview:
- Keypad front-end that sits directly upstream of the vending machine controller.
- Collects a two-digit item code after a card is inserted, with per-digit timeout.
- Validates the code against the 00–19 item range.
- Presents a stable 5-bit item index with a valid/accept handshake to the controller, or pulses an error or timeout indication instead.

Parameters:
- TIMEOUT_CYCLES, 5, consecutive cycles without a key event before entry aborts (legal range 2–15).
- MAX_ITEM, 19, highest legal item index.
- CODE_W, 4, width of the ITEM_CODE keypad digit bus.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  reset.
- CARD_IN  in  1  card present (level).
- KEY_PRESS  in  1  key held (level); synchronous to CLK.
- ITEM_CODE  in  CODE_W  digit of the current key.
- ACCEPT  in  1  downstream has consumed SEL_ITEM.
- SEL_VALID  out  1  SEL_ITEM holds a legal code.
- SEL_ITEM  out  5  item index 0..MAX_ITEM.
- INVALID_SEL  out  1  one-cycle pulse: illegal digit.
- TIMEOUT  out  1  one-cycle pulse: entry timed out.
- BUSY  out  1  entry in progress (any state except IDLE).

Interface (already decided):
- One clock; reset is asynchronous and active-low.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - All outputs 0; state IDLE.
  - Timeout counter, tens register and edge-detect register cleared.
  - Takes effect immediately, including mid-entry.
- All outputs are registered.
- Key event: KEY_PRESS=1 at edge k and KEY_PRESS=0 at edge k-1. ITEM_CODE is sampled at edge k. A held key produces one event only.
- Card edge: CARD_IN=1 at edge k and CARD_IN=0 at edge k-1.
- States and transitions:
  - IDLE: on card edge -> WAIT_D1, counter=0.
  - WAIT_D1:
    - Key event with digit 0 -> tens=0, go to WAIT_D2.
    - Key event with digit 1 -> tens=1, go to WAIT_D2.
    - Key event with any other digit -> INVALID_SEL pulse, go to IDLE.
  - WAIT_D2:
    - Key event with digit d ≤ 9 -> SEL_ITEM = tens*10 + d, SEL_VALID=1, go to HOLD.
    - Key event with digit d > 9, or a result > MAX_ITEM -> INVALID_SEL pulse, go to IDLE.
  - HOLD:
    - SEL_VALID=1 and SEL_ITEM is stable.
    - On ACCEPT=1 at an edge -> SEL_VALID=0, go to IDLE.
    - Key events are ignored.
    - No timeout applies.
- Timeout (WAIT_D1 and WAIT_D2 only):
  - Counter clears on state entry and on every key event; otherwise it increments each cycle.
  - If counter==TIMEOUT_CYCLES-1 with no key event that cycle -> TIMEOUT pulse, go to IDLE.
  - Net effect: the pulse fires on the TIMEOUT_CYCLES-th idle edge.
- CARD_IN=0 in WAIT_D1, WAIT_D2 or HOLD: abort to IDLE next edge, SEL_VALID=0, no pulses. This takes priority over key, accept and timeout.
- Simultaneous events: a key event on the expiry cycle wins (no timeout). ACCEPT outside HOLD is ignored.
- Re-entry after completion or abort requires a new card edge; a card held continuously never re-arms.
- SEL_ITEM retains its last value when SEL_VALID=0. Only SEL_VALID qualifies it.
- Latency: SEL_VALID rises at the same edge as the second-digit key event.
- Arithmetic: tens*10 + d is computed in 5 bits; the maximum is 19, so there is no overflow.

Decomposition:
- Shared package (item_entry_pkg):
  - State enumeration IDLE/WAIT_D1/WAIT_D2/HOLD, encoded 2-bit.
  - ITEM_IDX_W=5.
  - Legal tens digits 0 and 1.
  - Default TIMEOUT_CYCLES.
- One sub-module, key_edge_detect:
  - Registered previous level, outputs a rise pulse.
  - Instantiated twice, for KEY_PRESS and for CARD_IN.

Test Plan:
- Card edge, keys 1 then 4 (one cycle apart, each held 2 cycles), ACCEPT low 3 cycles then high:
  - SEL_VALID=1 and SEL_ITEM=14 from the second key edge until the ACCEPT edge, then 0.
  - BUSY then falls.
- Card edge, first key 2 -> INVALID_SEL single pulse, state IDLE, SEL_VALID stays 0.
- Card edge, then keys 1 and 9, then 1 and 10 in separate sessions:
  - Keys 1,9 -> SEL_ITEM=19 valid.
  - Keys 1,10 (digit 0xA) -> INVALID_SEL pulse.
- Card edge, no keys:
  - TIMEOUT pulses exactly 5 cycles later.
  - Repeat with key 0 pressed on cycle 5: no timeout, enters WAIT_D2, and its counter restarts.
- Keys 0,7 -> HOLD, then CARD_IN drops -> SEL_VALID=0 next edge, no pulses. Re-insert card -> new entry accepted.
- RESET_N asserted asynchronously mid-WAIT_D2:
  - All outputs 0 immediately.
  - After release, a held CARD_IN does not re-arm until it toggles.
